avg_vector_sequencer: RTL and testbench

//  Sequences the vector output latch stage of the AVG. Accepts one command per

---
 rtl/avg_vector_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_avg_vector_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/avg_vector_sequencer.sv
// AVG vector output latch sequencer: strobe / scale-load / beam-on / centering wait.
// Optional build macro AVG_SEQ_STATS_EN adds the vec_cnt completed-DRAW counter.
module avg_vector_sequencer #(
    parameter int STROBE_W = 2,
    parameter int SETTLE   = 4,
    parameter int LEN_W    = 12,
    parameter int CTR_TMO  = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             x0_i,
    input  logic             y0_i,
    output logic             strobe_o,
    output logic             scaleld_n,
    output logic             go,
    output logic             busy,
    output logic             done,
    output logic             ctr_tmo
`ifdef AVG_SEQ_STATS_EN
    ,
    output logic [15:0]      vec_cnt
`endif
);

    localparam int TMO_W = $clog2(CTR_TMO + 1);
    localparam int CNT_W = (LEN_W > TMO_W) ? LEN_W : TMO_W;

    typedef enum logic [1:0] {
        OP_LDPOS   = 2'b00,
        OP_LDSCALE = 2'b01,
        OP_DRAW    = 2'b10,
        OP_CENTER  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB,
        S_SCL,
        S_SETTLE,
        S_DRAW,
        S_CTR,
        S_DONE
    } state_e;

    state_e           r_state;
    logic [1:0]       r_op;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic             w_zero_ok;

    assign w_zero_ok = x0_i & y0_i;

    // Outputs are set on the edge that enters each state, so every output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_len     <= '0;
            r_cnt     <= '0;
            cmd_ready <= 1'b1;
            strobe_o  <= 1'b0;
            scaleld_n <= 1'b1;
            go        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ctr_tmo   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_len     <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_LDSCALE) begin
                            scaleld_n <= 1'b0;
                            r_state   <= S_SCL;
                        end else begin
                            strobe_o <= 1'b1;
                            r_cnt    <= CNT_W'(STROBE_W - 1);
                            r_state  <= S_STB;
                            if (cmd_op == OP_CENTER)
                                ctr_tmo <= 1'b0;
                        end
                    end
                end
                S_STB: begin
                    if (r_cnt == '0) begin
                        strobe_o <= 1'b0;
                        case (r_op)
                            OP_DRAW: begin
                                r_cnt   <= CNT_W'(SETTLE - 1);
                                r_state <= S_SETTLE;
                            end
                            OP_CENTER: begin
                                r_cnt   <= '0;
                                r_state <= S_CTR;
                            end
                            default: begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SCL: begin
                    scaleld_n <= 1'b1;
                    done      <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        if (r_len == '0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            go      <= 1'b1;
                            r_cnt   <= CNT_W'(r_len - 1'b1);
                            r_state <= S_DRAW;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DRAW: begin
                    if (r_cnt == '0) begin
                        go      <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CTR: begin
                    // r_cnt counts sampled cycles; the CTR_TMO-th miss times out
                    if (w_zero_ok) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_W'(CTR_TMO - 1)) begin
                        ctr_tmo <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    strobe_o  <= 1'b0;
                    scaleld_n <= 1'b1;
                    go        <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef AVG_SEQ_STATS_EN
    // Only DRAWs with a nonzero length ever reach the last DRAW cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vec_cnt <= '0;
        else if (r_state == S_DRAW && r_cnt == '0 && vec_cnt != 16'hFFFF)
            vec_cnt <= vec_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_avg_vector_sequencer.sv
// Directed table-driven bench for avg_vector_sequencer plus reset-mid-DRAW sequence.
module tb_avg_vector_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_len = 12'd0;
    logic        x0_i = 1'b0;
    logic        y0_i = 1'b0;
    logic        strobe_o, scaleld_n, go, busy, done, ctr_tmo;
`ifdef AVG_SEQ_STATS_EN
    logic [15:0] vec_cnt;
`endif

    avg_vector_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .x0_i      (x0_i),
        .y0_i      (y0_i),
        .strobe_o  (strobe_o),
        .scaleld_n (scaleld_n),
        .go        (go),
        .busy      (busy),
        .done      (done),
        .ctr_tmo   (ctr_tmo)
`ifdef AVG_SEQ_STATS_EN
        ,
        .vec_cnt   (vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] len;
        int          xy_at;   // cycle after accept at which x0&y0 go high (0 = never)
        int          lat;
        int          stb;
        int          scl;
        int          go_n;
        int          go_at;
        int          tmo;
    } vec_t;

    vec_t tbl [10];
    int   n_chk = 0;
    int   n_err = 0;
    int   r_lat, r_stb, r_scl, r_go, r_go1, r_dn, r_bad, r_rdy, r_post;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_cmd(input logic [1:0] op, input logic [11:0] len, input int xy_at);
        r_lat = 0; r_stb = 0; r_scl = 0; r_go = 0; r_go1 = 0; r_dn = 0; r_bad = 0;
        r_rdy = int'(cmd_ready);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len;
        for (int k = 1; k <= 400 && r_lat == 0; k++) begin
            @(negedge clk);
            x0_i = 1'b1;
            y0_i = (xy_at > 0 && k >= xy_at);
            if (strobe_o) r_stb++;
            if (!scaleld_n) r_scl++;
            if (go) begin
                r_go++;
                if (r_go1 == 0) r_go1 = k;
            end
            if ((go && strobe_o) || (go && !scaleld_n) || !busy || cmd_ready) r_bad++;
            if (done) begin
                r_dn++;
                r_lat = k;
            end
        end
        @(negedge clk);
        x0_i = 1'b0; y0_i = 1'b0;
        r_post = int'({done, busy, cmd_ready});
    endtask

    initial begin
        int exp_vec;
        int seen_done;
        tbl[0] = '{2'b00, 12'd0, 0,   3, 2, 0, 0, 0, 0};
        tbl[1] = '{2'b01, 12'd9, 0,   2, 0, 1, 0, 0, 0};
        tbl[2] = '{2'b10, 12'd5, 0,  12, 2, 0, 5, 7, 0};
        tbl[3] = '{2'b10, 12'd0, 0,   7, 2, 0, 0, 0, 0};
        tbl[4] = '{2'b11, 12'd0, 13, 14, 2, 0, 0, 0, 0};
        tbl[5] = '{2'b11, 12'd0, 0, 258, 2, 0, 0, 0, 1};
        tbl[6] = '{2'b00, 12'd3, 0,   3, 2, 0, 0, 0, 1};
        tbl[7] = '{2'b11, 12'd0, 3,   4, 2, 0, 0, 0, 0};
        tbl[8] = '{2'b10, 12'd7, 0,  14, 2, 0, 7, 7, 0};
        tbl[9] = '{2'b10, 12'd1, 0,   8, 2, 0, 1, 7, 0};
        exp_vec = 0;

        #12;
        chk("rst_outputs", int'({cmd_ready, strobe_o, scaleld_n, go, busy, done, ctr_tmo}), 7'b1010000);
`ifdef AVG_SEQ_STATS_EN
        chk("rst_vec_cnt", int'(vec_cnt), 0);
`endif
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].op, tbl[i].len, tbl[i].xy_at);
            chk($sformatf("v%0d_ready_pre", i), r_rdy, 1);
            chk($sformatf("v%0d_latency", i), r_lat, tbl[i].lat);
            chk($sformatf("v%0d_strobe_cyc", i), r_stb, tbl[i].stb);
            chk($sformatf("v%0d_scaleld_cyc", i), r_scl, tbl[i].scl);
            chk($sformatf("v%0d_go_cyc", i), r_go, tbl[i].go_n);
            if (tbl[i].go_n > 0)
                chk($sformatf("v%0d_go_start", i), r_go1, tbl[i].go_at);
            chk($sformatf("v%0d_done_pulses", i), r_dn, 1);
            chk($sformatf("v%0d_overlap_busy", i), r_bad, 0);
            chk($sformatf("v%0d_post_dbr", i), r_post, 3'b001);
            chk($sformatf("v%0d_ctr_tmo", i), int'(ctr_tmo), tbl[i].tmo);
            if (tbl[i].op == 2'b10 && tbl[i].len != 0) exp_vec++;
        end
`ifdef AVG_SEQ_STATS_EN
        chk("vec_cnt", int'(vec_cnt), exp_vec);
`endif

        // Reset in the middle of the beam-on window.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 12'd20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_draw_go", int'(go), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({cmd_ready, strobe_o, scaleld_n, go, busy, done}), 6'b101000);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done || go || busy) seen_done++;
        end
        chk("rst_no_done", seen_done, 0);
        chk("rst_ready_after", int'(cmd_ready), 1);
`ifdef AVG_SEQ_STATS_EN
        chk("rst_vec_cnt_clr", int'(vec_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
